// File: rtl/bru_pred_stage.sv
// Pipelined branch resolution stage: resolves condition and next PC, flags mispredicts,
// trains a 2-bit saturating BHT and keeps saturating branch/mispredict statistics.
module bru_pred_stage #(
  parameter int DATA_W    = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic              pred_taken,
  input  logic [DATA_W-1:0] pred_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_br,
  output logic              out_taken,
  output logic [DATA_W-1:0] out_next_pc,
  output logic [DATA_W-1:0] out_link,
  output logic              out_mispredict,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              lookup_taken,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam logic [3:0] OP_EQ   = 4'd1;
  localparam logic [3:0] OP_NE   = 4'd2;
  localparam logic [3:0] OP_LT   = 4'd3;
  localparam logic [3:0] OP_GE   = 4'd4;
  localparam logic [3:0] OP_LTU  = 4'd5;
  localparam logic [3:0] OP_GEU  = 4'd6;
  localparam logic [3:0] OP_JAL  = 4'd7;
  localparam logic [3:0] OP_JALR = 4'd8;
  localparam int         BHT_N   = 2 ** BHT_IDX_W;

  logic                 out_valid_q, out_is_br_q, out_taken_q, out_mispred_q;
  logic [DATA_W-1:0]    out_next_pc_q, out_link_q;
  logic                 train_q;
  logic [BHT_IDX_W-1:0] bht_idx_q;
  logic [CNT_W-1:0]     branch_cnt_q, mispred_cnt_q;
  logic [1:0]           bht_q [BHT_N];

  logic                 accept, out_hs;
  logic                 is_cond, is_jump, taken_d, mispred_d;
  logic [DATA_W-1:0]    br_target, jalr_sum, link_d, next_pc_d;
  logic [1:0]           bht_cur, bht_d;

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready && !flush;

  always_comb begin
    is_cond = (op >= OP_EQ) && (op <= OP_GEU);
    is_jump = (op == OP_JAL) || (op == OP_JALR);
    taken_d = 1'b0;
    case (op)
      OP_EQ:   taken_d = (src1 == src2);
      OP_NE:   taken_d = (src1 != src2);
      OP_LT:   taken_d = ($signed(src1) <  $signed(src2));
      OP_GE:   taken_d = ($signed(src1) >= $signed(src2));
      OP_LTU:  taken_d = (src1 <  src2);
      OP_GEU:  taken_d = (src1 >= src2);
      OP_JAL,
      OP_JALR: taken_d = 1'b1;
      default: taken_d = 1'b0;
    endcase
  end

  assign br_target = pc + imm;
  assign jalr_sum  = src1 + imm;
  assign link_d    = pc + DATA_W'(4);
  assign next_pc_d = !taken_d        ? link_d :
                     (op == OP_JALR) ? {jalr_sum[DATA_W-1:1], 1'b0} : br_target;
  assign mispred_d = (taken_d != pred_taken) || (taken_d && (next_pc_d != pred_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_is_br_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_mispred_q <= 1'b0;
      out_next_pc_q <= '0;
      out_link_q    <= '0;
      train_q       <= 1'b0;
      bht_idx_q     <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        out_is_br_q   <= is_cond || is_jump;
        out_taken_q   <= taken_d;
        out_mispred_q <= mispred_d;
        out_next_pc_q <= next_pc_d;
        out_link_q    <= link_d;
        train_q       <= is_cond;
        bht_idx_q     <= pc[BHT_IDX_W+1:2];
      end
    end
  end

  // Training uses the registered outcome, so only results actually consumed move the table.
  assign bht_cur = bht_q[bht_idx_q];
  assign bht_d   = out_taken_q ? ((bht_cur == 2'd3) ? 2'd3 : bht_cur + 2'd1)
                               : ((bht_cur == 2'd0) ? 2'd0 : bht_cur - 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (out_hs && train_q) begin
      bht_q[bht_idx_q] <= bht_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (out_hs && out_is_br_q) begin
      if (branch_cnt_q != {CNT_W{1'b1}}) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (out_mispred_q && (mispred_cnt_q != {CNT_W{1'b1}})) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign lookup_taken   = bht_q[lookup_pc[BHT_IDX_W+1:2]][1];
  assign out_valid      = out_valid_q;
  assign out_is_br      = out_is_br_q;
  assign out_taken      = out_taken_q;
  assign out_next_pc    = out_next_pc_q;
  assign out_link       = out_link_q;
  assign out_mispredict = out_mispred_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule
